// File: rtl/mem_responder_pkg.sv
// Shared constants for the memory responder: default geometry, latency and FSM state encoding.
package mem_responder_pkg;

  localparam int MEM_ADDR_W  = 12;
  localparam int MEM_DATA_W  = 31;
  localparam int MEM_LATENCY = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE       = 2'd0;
  localparam state_t ST_READ_WAIT  = 2'd1;
  localparam state_t ST_WRITE_WAIT = 2'd2;

  // Down-counter width needed to hold values 0..latency.
  function automatic int count_width(input int latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Controller-to-memory handshake bundle: one-cycle request pulses in, reply/status out.
interface mem_responder_if
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
);

  logic              mem_read_pulse;
  logic              mem_write_pulse;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;
  logic              mem_reply;
  logic              mem_busy;
  logic              mem_overrun;

  modport master (
    output mem_read_pulse, mem_write_pulse, mem_addr, mem_write_data,
    input  mem_read_data, mem_reply, mem_busy, mem_overrun
  );

  modport slave (
    input  mem_read_pulse, mem_write_pulse, mem_addr, mem_write_data,
    output mem_read_data, mem_reply, mem_busy, mem_overrun
  );

endinterface

// File: rtl/mem_array.sv
// Word storage with synchronous write and a registered read port; only the read register is reset.
module mem_array #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The read word is held until the next read so the controller can sample it at leisure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts single read/write pulses, times the wait with a
// down-counter and raises a one-cycle reply; rejected pulses set a sticky overrun flag.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int LATENCY = MEM_LATENCY
) (
  input logic           clk,
  input logic           rst_n,
  mem_responder_if.slave bus
);

  localparam int CNT_W = count_width(LATENCY);

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] addr_q;
  logic              reply_q;
  logic              overrun_q;

  logic idle;
  logic accept_rd;
  logic accept_wr;
  logic reject;
  logic fire;
  logic rd_en;

  always_comb begin
    idle      = (state == ST_IDLE);
    accept_rd = idle && bus.mem_read_pulse && !bus.mem_write_pulse;
    accept_wr = idle && bus.mem_write_pulse && !bus.mem_read_pulse;
    reject    = (!idle && (bus.mem_read_pulse || bus.mem_write_pulse)) ||
                (bus.mem_read_pulse && bus.mem_write_pulse);
    // The edge leaving count 1 is the one that raises the reply and registers the read word.
    fire      = !idle && (count == CNT_W'(1));
    rd_en     = fire && (state == ST_READ_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      count     <= '0;
      addr_q    <= '0;
      reply_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      reply_q <= fire;
      if (reject) begin
        overrun_q <= 1'b1;
      end
      if (idle) begin
        if (accept_rd || accept_wr) begin
          state  <= accept_rd ? ST_READ_WAIT : ST_WRITE_WAIT;
          count  <= CNT_W'(LATENCY - 1);
          addr_q <= bus.mem_addr;
        end
      end else if (count == '0) begin
        state <= ST_IDLE;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept_wr),
    .wr_addr (bus.mem_addr),
    .wr_data (bus.mem_write_data),
    .rd_en   (rd_en),
    .rd_addr (addr_q),
    .rd_data (bus.mem_read_data)
  );

  assign bus.mem_reply   = reply_q;
  assign bus.mem_busy    = !idle;
  assign bus.mem_overrun = overrun_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: latency-3 instance for the main flows, latency-2 instance
// for the top-address read.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam logic [30:0] W0001 = 31'o0011112222;
  localparam logic [30:0] W2222 = 31'o2222222222;
  localparam logic [30:0] W0005 = 31'o0505050505;
  localparam logic [30:0] W3333 = 31'o3333333333;
  localparam logic [30:0] W7777 = 31'o7654321076;
  localparam logic [30:0] JUNK  = 31'o1234567012;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  mem_responder_if #(.ADDR_W(MEM_ADDR_W), .DATA_W(MEM_DATA_W)) bus3 ();
  mem_responder_if #(.ADDR_W(MEM_ADDR_W), .DATA_W(MEM_DATA_W)) bus2 ();

  mem_responder #(.ADDR_W(MEM_ADDR_W), .DATA_W(MEM_DATA_W), .LATENCY(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  mem_responder #(.ADDR_W(MEM_ADDR_W), .DATA_W(MEM_DATA_W), .LATENCY(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkStatus(input string tag, input logic reply, input logic busy,
                             input logic overrun);
    checkOutput({tag, " reply"}, {31'd0, bus3.mem_reply}, {31'd0, reply});
    checkOutput({tag, " busy"}, {31'd0, bus3.mem_busy}, {31'd0, busy});
    checkOutput({tag, " overrun"}, {31'd0, bus3.mem_overrun}, {31'd0, overrun});
  endtask

  // Drives one pulse cycle on the latency-3 bus and returns one cycle later with pulses low.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [11:0] addr,
                               input logic [30:0] wdata);
    bus3.mem_read_pulse  = rd;
    bus3.mem_write_pulse = wr;
    bus3.mem_addr        = addr;
    bus3.mem_write_data  = wdata;
    tick();
    bus3.mem_read_pulse  = 1'b0;
    bus3.mem_write_pulse = 1'b0;
  endtask

  initial begin
    bus3.mem_read_pulse  = 1'b0;
    bus3.mem_write_pulse = 1'b0;
    bus3.mem_addr        = '0;
    bus3.mem_write_data  = '0;
    bus2.mem_read_pulse  = 1'b0;
    bus2.mem_write_pulse = 1'b0;
    bus2.mem_addr        = '0;
    bus2.mem_write_data  = '0;
    dut3.u_array.mem[12'o0001] = W0001;
    dut3.u_array.mem[12'o2222] = W2222;
    dut3.u_array.mem[12'o0005] = W0005;
    dut2.u_array.mem[12'o7777] = W7777;

    // Reset state, with a read pulse held across an edge while in reset.
    bus3.mem_read_pulse = 1'b1;
    bus3.mem_addr       = 12'o0001;
    tick();
    tick();
    checkStatus("reset", 1'b0, 1'b0, 1'b0);
    checkOutput("reset rdata", {1'b0, bus3.mem_read_data}, 32'd0);
    bus3.mem_read_pulse = 1'b0;
    rst_n = 1'b1;
    tick();
    checkStatus("post release", 1'b0, 1'b0, 1'b0);

    // Read path.
    applyStimulus(1'b1, 1'b0, 12'o0001, JUNK);
    checkStatus("rd n+1", 1'b0, 1'b1, 1'b0);
    tick();
    checkStatus("rd n+2", 1'b0, 1'b1, 1'b0);
    tick();
    checkStatus("rd n+3", 1'b1, 1'b1, 1'b0);
    checkOutput("rd data", {1'b0, bus3.mem_read_data}, {1'b0, W0001});
    tick();
    checkStatus("rd n+4", 1'b0, 1'b0, 1'b0);
    checkOutput("rd data held", {1'b0, bus3.mem_read_data}, {1'b0, W0001});

    // Write then back-to-back read.
    applyStimulus(1'b0, 1'b1, 12'o1111, W3333);
    checkStatus("wr n+1", 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    checkStatus("wr n+3", 1'b1, 1'b1, 1'b0);
    checkOutput("wr no rdata change", {1'b0, bus3.mem_read_data}, {1'b0, W0001});
    tick();
    checkStatus("wr n+4", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 12'o1111, JUNK);
    tick();
    checkStatus("wr-rd n+6", 1'b0, 1'b1, 1'b0);
    tick();
    checkStatus("wr-rd n+7", 1'b1, 1'b1, 1'b0);
    checkOutput("wr-rd data", {1'b0, bus3.mem_read_data}, {1'b0, W3333});
    tick();

    // Busy collision: second pulse at n+2, another in the reply cycle.
    applyStimulus(1'b1, 1'b0, 12'o2222, JUNK);
    tick();
    applyStimulus(1'b1, 1'b0, 12'o0001, JUNK);
    checkStatus("coll n+3", 1'b1, 1'b1, 1'b1);
    checkOutput("coll data", {1'b0, bus3.mem_read_data}, {1'b0, W2222});
    applyStimulus(1'b0, 1'b1, 12'o0005, JUNK);
    checkStatus("coll n+4", 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checkStatus("coll n+6", 1'b0, 1'b0, 1'b1);

    // Reset clears the sticky flag immediately.
    rst_n = 1'b0;
    #1;
    checkStatus("ovr reset", 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Simultaneous read and write both rejected; word at 0005 untouched.
    applyStimulus(1'b1, 1'b1, 12'o0005, JUNK);
    checkStatus("both n+1", 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checkStatus("both n+3", 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 12'o0005, JUNK);
    tick();
    tick();
    checkStatus("rd 0005", 1'b1, 1'b1, 1'b1);
    checkOutput("rd 0005 data", {1'b0, bus3.mem_read_data}, {1'b0, W0005});
    tick();

    // Reset in the middle of a read aborts it.
    applyStimulus(1'b1, 1'b0, 12'o0001, JUNK);
    tick();
    rst_n = 1'b0;
    #1;
    checkStatus("abort", 1'b0, 1'b0, 1'b0);
    checkOutput("abort rdata", {1'b0, bus3.mem_read_data}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checkStatus("abort after", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 12'o0001, JUNK);
    checkStatus("rerd n+1", 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    checkStatus("rerd n+3", 1'b1, 1'b1, 1'b0);
    checkOutput("rerd data", {1'b0, bus3.mem_read_data}, {1'b0, W0001});
    tick();

    // Latency 2, top address.
    bus2.mem_read_pulse = 1'b1;
    bus2.mem_addr       = 12'o7777;
    tick();
    bus2.mem_read_pulse = 1'b0;
    checkOutput("l2 n+1 reply", {31'd0, bus2.mem_reply}, 32'd0);
    checkOutput("l2 n+1 busy", {31'd0, bus2.mem_busy}, 32'd1);
    tick();
    checkOutput("l2 n+2 reply", {31'd0, bus2.mem_reply}, 32'd1);
    checkOutput("l2 data", {1'b0, bus2.mem_read_data}, {1'b0, W7777});
    tick();
    checkOutput("l2 n+3 reply", {31'd0, bus2.mem_reply}, 32'd0);
    checkOutput("l2 n+3 busy", {31'd0, bus2.mem_busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 12, word address width (4096 words).
REQ-002 Parameter DATA_W, default 31, memory word width (sign + 30 bits).
REQ-003 Parameter LATENCY, default 3, cycles from the accepted pulse edge to the mem_reply cycle; legal range 2..15.
REQ-004 clk  input  1  single clock; all state on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 mem_read_pulse  input  1  one-cycle read request from the controller.
REQ-007 mem_write_pulse  input  1  one-cycle write request from the controller.
REQ-008 mem_addr  input  ADDR_W  word address (controller select register), sampled with the pulse.
REQ-009 mem_write_data  input  DATA_W  write word, sampled with mem_write_pulse.
REQ-010 mem_read_data  output  DATA_W  read word, valid from the mem_reply cycle and held until the next accepted read.
REQ-011 mem_reply  output  1  one-cycle completion strobe for both reads and writes.
REQ-012 mem_busy  output  1  high while a request is outstanding.
REQ-013 mem_overrun  output  1  sticky error flag for rejected requests.

Function
REQ-014 States: IDLE, READ_WAIT and WRITE_WAIT; a down-counter of width ceil(log2(LATENCY+1)) times the wait.
REQ-015 In IDLE, exactly one pulse high shall be accepted:
- latch mem_addr (and mem_write_data for a write);
- load counter with LATENCY-1;
- enter READ_WAIT or WRITE_WAIT.
REQ-016 An accepted write shall update the array at the accept edge; a reset arriving afterwards does not undo it.
REQ-017 In a WAIT state the counter decrements each cycle; when it reaches 0, mem_reply is high for exactly one cycle and the state returns to IDLE on the next edge.
REQ-018 For a read, the array word at the latched address is registered into mem_read_data on the edge that raises mem_reply.
- Pulse at cycle n gives mem_reply at cycle n+LATENCY.
REQ-019 mem_busy is high from the cycle after acceptance through the mem_reply cycle inclusive.
REQ-020 A pulse arriving while mem_busy is high shall be ignored (no array change, no extra reply) and shall set mem_overrun.
REQ-021 A read and a write pulse in the same IDLE cycle shall both be ignored, and mem_overrun shall be set.
REQ-022 A pulse in the cycle that mem_reply is high shall be treated as busy (REQ-020); the earliest back-to-back accept is the cycle after mem_reply.
REQ-023 Addresses wrap naturally within ADDR_W bits; there is no out-of-range condition.
REQ-024 mem_overrun clears only on reset.

Reset
REQ-025 rst_n low shall immediately give:
- state IDLE, counter 0;
- mem_reply 0, mem_busy 0, mem_overrun 0;
- mem_read_data all zero.
REQ-026 Reset during a WAIT state shall abort the transaction without a mem_reply.
REQ-027 Array contents shall not be reset; the bench preloads them hierarchically.
REQ-028 Pulses are ignored while rst_n is low; the first accept is possible on the first edge after release.

Structure
REQ-029 The shared package shall hold:
- ADDR_W, DATA_W and default LATENCY;
- the state encoding (IDLE=0, READ_WAIT=1, WRITE_WAIT=2).
REQ-030 One sub-module, mem_array: synchronous-write, registered-read 2^ADDR_W x DATA_W storage. mem_responder contains only the FSM, counter and flags.

Verification
REQ-031 Read path: preload 0001 = 0_00_1111_2222 (octal), read pulse at cycle n with addr 0001 -> mem_reply at n+3 only, mem_read_data = 0_00_1111_2222, mem_busy high n+1..n+3.
REQ-032 Write then read: write 0_33_3333_3333 to 1111, reply at n+3; read 1111 at n+4 -> reply at n+7 with 0_33_3333_3333.
REQ-033 Busy collision: read 2222, second read pulse at n+2 -> single reply at n+3, mem_overrun = 1 and stays 1; pulse at n+3 also rejected.
REQ-034 Simultaneous read and write at 0005 -> no reply, word at 0005 unchanged, mem_overrun = 1.
REQ-035 Reset mid-read: drop rst_n at n+2 -> no reply, outputs zero; a read of 0001 after release completes with normal latency.
REQ-036 Wrap and latency: LATENCY=2, read addr 7777 -> reply at n+2 with the preloaded 7777 word.
